// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the CPU's UART data-register write strobe and uart_tx.
// Buffers writes without stalling the CPU and launches bytes one at a time, honouring tx_busy.
module uart_tx_fifo #(
  parameter  int DEPTH   = 16,
  localparam int LEVEL_W = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [7:0]         wr_data,
  output logic               full,
  output logic               empty,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  input  logic               ovf_clear,
  output logic               tx_en,
  output logic [7:0]         tx_data,
  input  logic               tx_busy
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               wr_accept, wr_drop, pop;

  assign full      = (count == LEVEL_W'(DEPTH));
  assign empty     = (count == '0);
  assign level     = count;
  assign wr_accept = wr_en && !full;
  assign wr_drop   = wr_en && full;
  // A pop only happens from IDLE, so it never coincides with a write into an empty FIFO.
  assign pop       = (state == IDLE) && (count != '0) && !tx_busy;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default first so every path assigns state_nxt and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = HOLD;
      HOLD:    state_nxt = IDLE; // covers uart_tx's busy-assert latency
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_en = (state == LAUNCH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      tx_data  <= 8'h00;
    end else begin
      if (wr_accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_W'(1);
        tx_data <= mem[rd_ptr];
      end
      case ({wr_accept, pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
      // A dropped write beats a same-cycle clear so the loss is never hidden.
      if (wr_drop)        overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  // NOTE: storage is deliberately not reset; count and pointers gate every read,
  // so stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised self-checking bench for uart_tx_fifo against a queue-based reference model
// with an optional uart_tx busy emulator.
module tb_uart_tx_fifo;

  localparam int DEPTH    = 16;
  localparam int LEVEL_W  = $clog2(DEPTH) + 1;
  localparam int BUSY_LEN = 1040;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               wr_en = 1'b0;
  logic [7:0]         wr_data = 8'h00;
  logic               ovf_clear = 1'b0;
  logic               tx_busy = 1'b0;
  logic               full, empty, overflow, tx_en;
  logic [LEVEL_W-1:0] level;
  logic [7:0]         tx_data;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .empty     (empty),
    .level     (level),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .tx_en     (tx_en),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: byte queue plus the launch-spacing rule expressed in cycles.
  logic [7:0] mdl_q[$];
  logic [7:0] acc_log[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_tx_data = 8'h00;
  bit         exp_tx_en = 1'b0;
  bit         exp_ovf = 1'b0;
  int         cyc = 0;
  int         last_pop = -1000;
  int         n_pulse = 0;
  bit         emu_on = 1'b0;
  int         emu_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit was_full;
    bit do_pop;
    if (rst) begin
      mdl_q.delete();
      exp_tx_en   = 1'b0;
      exp_tx_data = 8'h00;
      exp_ovf     = 1'b0;
      last_pop    = -1000;
    end else begin
      was_full  = (mdl_q.size() == DEPTH);
      do_pop    = (mdl_q.size() != 0) && !tx_busy && (cyc - last_pop >= 3);
      exp_tx_en = do_pop;
      if (do_pop) begin
        exp_tx_data = mdl_q.pop_front();
        last_pop    = cyc;
      end
      if (wr_en) begin
        if (was_full) exp_ovf = 1'b1;
        else begin
          mdl_q.push_back(wr_data);
          acc_log.push_back(wr_data);
        end
      end
      if (!(wr_en && was_full) && ovf_clear) exp_ovf = 1'b0;
    end
  endtask

  task automatic tick();
    bit en_now;
    model_step();
    en_now = tx_en;
    @(posedge clk);
    #1;
    cyc++;
    if (emu_on) begin
      if (en_now)           emu_cnt = BUSY_LEN;
      else if (emu_cnt > 0) emu_cnt--;
      tx_busy = (emu_cnt != 0);
    end
    check("tx_en",    tx_en,    exp_tx_en);
    check("tx_data",  tx_data,  exp_tx_data);
    check("level",    level,    mdl_q.size());
    check("full",     full,     mdl_q.size() == DEPTH);
    check("empty",    empty,    mdl_q.size() == 0);
    check("overflow", overflow, exp_ovf);
    if (tx_en) begin
      got_q.push_back(tx_data);
      n_pulse++;
    end
  endtask

  task automatic idle_ticks(input int n);
    wr_en = 1'b0;
    ovf_clear = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic compare_seq(input string tag, input logic [7:0] exp_q[$]);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check(tag, got_q[i], exp_q[i]);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    int         guard;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_level", level, 0);
    check("rst_tx_en", tx_en, 0);

    // 1: single byte latency N -> N+2
    write_byte(8'h41);
    check("t1_level1", level, 1);
    tick();
    check("t1_tx_en", tx_en, 1);
    check("t1_data", tx_data, 8'h41);
    check("t1_level0", level, 0);
    idle_ticks(4);

    // 2: fill while busy, overflow on 17th, ordered drain
    tx_busy = 1'b1;
    for (int i = 1; i <= 16; i++) write_byte(8'(i));
    check("t2_full", full, 1);
    check("t2_level16", level, 16);
    write_byte(8'hAA);
    check("t2_ovf", overflow, 1);
    got_q.delete();
    tx_busy = 1'b0;
    idle_ticks(60);
    exp_q.delete();
    for (int i = 1; i <= 16; i++) exp_q.push_back(8'(i));
    compare_seq("t2_order", exp_q);

    // 3: uart_tx emulator with long busy, burst of 5
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    got_q.delete();
    n_pulse = 0;
    emu_on  = 1'b1;
    emu_cnt = 0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(8'($urandom));
      write_byte(exp_q[i]);
    end
    idle_ticks(5 * (BUSY_LEN + 4) + 10);
    check("t3_pulses", n_pulse, 5);
    compare_seq("t3_order", exp_q);
    emu_on  = 1'b0;
    tx_busy = 1'b0;
    idle_ticks(4);

    // 4: pop at LAUNCH edge with same-cycle write into full FIFO
    tx_busy = 1'b1;
    got_q.delete();
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(8'h20 + i));
      write_byte(8'(8'h20 + i));
    end
    tx_busy = 1'b0;
    write_byte(8'h55);
    check("t4_ovf", overflow, 1);
    check("t4_level15", level, 15);
    tx_busy = 1'b1;
    write_byte(8'h66);
    exp_q.push_back(8'h66);
    check("t4_level16", level, 16);
    tx_busy = 1'b0;
    idle_ticks(80);
    compare_seq("t4_order", exp_q);

    // 5: overflow clear alone, then clear colliding with a drop
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;
    check("t5_clr", overflow, 0);
    tx_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'($urandom));
    ovf_clear = 1'b1;
    write_byte(8'hEE);
    ovf_clear = 1'b0;
    check("t5_set_wins", overflow, 1);
    tx_busy = 1'b0;
    idle_ticks(80);
    ovf_clear = 1'b1;
    tick();
    ovf_clear = 1'b0;

    // 6: random interleaved traffic across pointer wrap
    acc_log.delete();
    got_q.delete();
    guard = 0;
    while (acc_log.size() < 20 && guard < 2000) begin
      wr_en   = ($urandom_range(0, 2) != 0);
      wr_data = 8'($urandom);
      tx_busy = ($urandom_range(0, 3) == 0);
      tick();
      guard++;
    end
    check("t6_budget", guard < 2000, 1);
    wr_en   = 1'b0;
    tx_busy = 1'b0;
    idle_ticks(80);
    compare_seq("t6_order", acc_log);

    // 6b: reset while in HOLD with level 3
    tx_busy = 1'b1;
    for (int i = 0; i < 4; i++) write_byte(8'(8'hC0 + i));
    tx_busy = 1'b0;
    tick();
    check("t6_launch", tx_en, 1);
    tx_busy = 1'b1;
    tick();
    check("t6_hold_level", level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_level", level, 0);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_tx_en", tx_en, 0);
    tx_busy = 1'b0;
    n_pulse = 0;
    idle_ticks(10);
    check("t6_no_launch", n_pulse, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
